// File: rtl/fc_pkg.sv
// Shared definitions for the FC receive path: word layout, K28.5 and
// the word-class / sync-state enumerations.
package fc_pkg;

   localparam logic [7:0] K28_5 = 8'hBC;

   // One transmission word = 4 lanes of {K, byte}; byte 0 is sent first.
   localparam int unsigned WORD_W  = 36;
   localparam int unsigned LANE_W  = 9;
   localparam int unsigned K_OFS   = 8;
   localparam int unsigned BYTE0_L = 0;
   localparam int unsigned K0_BIT  = 0 * LANE_W + K_OFS;
   localparam int unsigned K1_BIT  = 1 * LANE_W + K_OFS;
   localparam int unsigned K2_BIT  = 2 * LANE_W + K_OFS;
   localparam int unsigned K3_BIT  = 3 * LANE_W + K_OFS;

   typedef enum logic [1:0] {
      WC_DATA,
      WC_OS,
      WC_INVALID
   } word_class_e;

   typedef enum logic [1:0] {
      HUNT,
      ACQ,
      SYNCED
   } sync_state_e;

endpackage

// File: rtl/fc_word_classify.sv
// Combinational classifier: data word, ordered set (K28.5 lead) or invalid.
module fc_word_classify
   import fc_pkg::*;
(
   input  logic [WORD_W-1:0] rx_data,
   input  logic              rx_valid,
   output word_class_e       word_class
);

   logic [3:0] k_bits;
   logic [7:0] byte0;

   // Pick out K flags and the leading byte, then classify.
   always_comb begin
      k_bits     = {rx_data[K3_BIT], rx_data[K2_BIT], rx_data[K1_BIT], rx_data[K0_BIT]};
      byte0      = rx_data[BYTE0_L +: 8];
      word_class = WC_INVALID;
      if (rx_valid) begin
         if (k_bits == 4'b0000)
            word_class = WC_DATA;
         else if (k_bits == 4'b0001 && byte0 == K28_5)
            word_class = WC_OS;
      end
   end

endmodule

// File: rtl/fc_rx_sync.sv
// Receive word synchronization: acquire on consecutive ordered sets,
// lose sync on net invalid-word credit, forward words while synced.
// Optional statistics counters: define FC_RX_SYNC_STATS_EN.
module fc_rx_sync
   import fc_pkg::*;
#(
   parameter int unsigned ACQ_OS_COUNT   = 3,
   parameter int unsigned LOSS_ERR_COUNT = 4,
   parameter int unsigned CNT_W          = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [WORD_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_os,
   output logic              sync,
   output logic              err,
   output logic [CNT_W-1:0]  invalid_count,
   output logic [CNT_W-1:0]  los_count
);

   localparam logic [2:0] ACQ_N  = ACQ_OS_COUNT[2:0];
   localparam logic [2:0] LOSS_N = LOSS_ERR_COUNT[2:0];

   word_class_e       cls;
   sync_state_e       state_q, state_d;
   logic [2:0]        os_cnt_q, os_cnt_d;
   logic [2:0]        err_cnt_q, err_cnt_d;
   logic              good_run_q, good_run_d;
   logic [WORD_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              out_os_q, out_os_d;
   logic              sync_q, sync_d;
   logic              err_q, err_d;

   fc_word_classify u_classify (
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .word_class (cls)
   );

   // Next-state and registered-output computation.
   always_comb begin
      state_d    = state_q;
      os_cnt_d   = os_cnt_q;
      err_cnt_d  = err_cnt_q;
      good_run_d = good_run_q;
      case (state_q)
         HUNT: begin
            if (cls == WC_OS) begin
               state_d  = ACQ;
               os_cnt_d = 3'd1;
            end
         end
         ACQ: begin
            if (cls == WC_OS) begin
               if (os_cnt_q + 3'd1 == ACQ_N) begin
                  state_d    = SYNCED;
                  os_cnt_d   = '0;
                  err_cnt_d  = '0;
                  good_run_d = 1'b0;
               end else begin
                  os_cnt_d = os_cnt_q + 3'd1;
               end
            end else if (cls == WC_INVALID) begin
               state_d  = HUNT;
               os_cnt_d = '0;
            end
         end
         SYNCED: begin
            if (cls == WC_INVALID) begin
               good_run_d = 1'b0;
               if (err_cnt_q + 3'd1 == LOSS_N) begin
                  state_d   = HUNT;
                  os_cnt_d  = '0;
                  err_cnt_d = '0;
               end else begin
                  err_cnt_d = err_cnt_q + 3'd1;
               end
            end else if (err_cnt_q != '0) begin
               // Two consecutive valid words cancel one outstanding error.
               if (good_run_q) begin
                  err_cnt_d  = err_cnt_q - 3'd1;
                  good_run_d = 1'b0;
               end else begin
                  good_run_d = 1'b1;
               end
            end
         end
         default: begin
            state_d    = HUNT;
            os_cnt_d   = '0;
            err_cnt_d  = '0;
            good_run_d = 1'b0;
         end
      endcase

      out_data_d  = rx_data;
      out_valid_d = (cls != WC_INVALID) && (state_d == SYNCED);
      out_os_d    = (cls == WC_OS) && out_valid_d;
      sync_d      = (state_d == SYNCED);
      err_d       = (cls == WC_INVALID);
   end

   // State, internal counters and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= HUNT;
         os_cnt_q    <= '0;
         err_cnt_q   <= '0;
         good_run_q  <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_os_q    <= 1'b0;
         sync_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         os_cnt_q    <= os_cnt_d;
         err_cnt_q   <= err_cnt_d;
         good_run_q  <= good_run_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_os_q    <= out_os_d;
         sync_q      <= sync_d;
         err_q       <= err_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_os    = out_os_q;
   assign sync      = sync_q;
   assign err       = err_q;

`ifdef FC_RX_SYNC_STATS_EN
   logic [CNT_W-1:0] invalid_cnt_q, invalid_cnt_d;
   logic [CNT_W-1:0] los_cnt_q, los_cnt_d;

   // Saturating statistics updates.
   always_comb begin
      invalid_cnt_d = invalid_cnt_q;
      los_cnt_d     = los_cnt_q;
      if (cls == WC_INVALID && invalid_cnt_q != '1)
         invalid_cnt_d = invalid_cnt_q + CNT_W'(1);
      if (state_q == SYNCED && state_d == HUNT && los_cnt_q != '1)
         los_cnt_d = los_cnt_q + CNT_W'(1);
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         invalid_cnt_q <= '0;
         los_cnt_q     <= '0;
      end else begin
         invalid_cnt_q <= invalid_cnt_d;
         los_cnt_q     <= los_cnt_d;
      end
   end

   assign invalid_count = invalid_cnt_q;
   assign los_count     = los_cnt_q;
`else
   assign invalid_count = '0;
   assign los_count     = '0;
`endif

endmodule

// File: tb/tb_fc_rx_sync.sv
// Randomized self-checking bench for fc_rx_sync against a behavioural model.
module tb_fc_rx_sync;

   localparam int unsigned ACQ_N  = 3;
   localparam int unsigned LOSS_N = 4;
   localparam int unsigned CW     = 10;
`ifdef FC_RX_SYNC_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   localparam int unsigned CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [35:0]   rx_data;
   logic          rx_valid;
   logic [35:0]   out_data;
   logic          out_valid;
   logic          out_os;
   logic          sync;
   logic          err;
   logic [CW-1:0] invalid_count;
   logic [CW-1:0] los_count;

   always #5 clk = ~clk;

   fc_rx_sync #(
      .ACQ_OS_COUNT   (ACQ_N),
      .LOSS_ERR_COUNT (LOSS_N),
      .CNT_W          (CW)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_os        (out_os),
      .sync          (sync),
      .err           (err),
      .invalid_count (invalid_count),
      .los_count     (los_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_sync;
   int          m_os_run, m_errs, m_streak, m_inv, m_los;
   logic [35:0] exp_data;
   bit          exp_valid, exp_os, exp_err;

   function automatic logic [35:0] mk_word(input logic [3:0] k, input logic [31:0] b);
      return {k[3], b[31:24], k[2], b[23:16], k[1], b[15:8], k[0], b[7:0]};
   endfunction

   // 0 = data, 1 = ordered set, 2 = invalid
   function automatic int classify(input logic [35:0] w, input logic v);
      logic [3:0] k;
      k = {w[35], w[26], w[17], w[8]};
      if (!v) return 2;
      if (k == 4'b0000) return 0;
      if (k == 4'b0001 && w[7:0] == 8'hBC) return 1;
      return 2;
   endfunction

   function automatic int sat(input int x);
      return (x >= int'(CNT_MAX)) ? int'(CNT_MAX) : x + 1;
   endfunction

   task automatic model_reset();
      m_sync = 0; m_os_run = 0; m_errs = 0; m_streak = 0; m_inv = 0; m_los = 0;
      exp_data = '0; exp_valid = 0; exp_os = 0; exp_err = 0;
   endtask

   task automatic model_step(input logic [35:0] w, input logic v);
      int c;
      c = classify(w, v);
      if (c == 2) m_inv = sat(m_inv);
      if (!m_sync) begin
         if (c == 1) begin
            m_os_run++;
            if (m_os_run == int'(ACQ_N)) begin
               m_sync = 1; m_os_run = 0; m_errs = 0; m_streak = 0;
            end
         end else if (c == 2) begin
            m_os_run = 0;
         end
      end else begin
         if (c == 2) begin
            m_errs++; m_streak = 0;
            if (m_errs == int'(LOSS_N)) begin
               m_sync = 0; m_errs = 0; m_los = sat(m_los);
            end
         end else if (m_errs > 0) begin
            m_streak++;
            if (m_streak == 2) begin
               m_errs--; m_streak = 0;
            end
         end
      end
      exp_data  = w;
      exp_valid = (c != 2) && m_sync;
      exp_os    = (c == 1) && exp_valid;
      exp_err   = (c == 2);
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, ".data"},  64'(out_data),  64'(exp_data));
      check_eq({tag, ".valid"}, 64'(out_valid), 64'(exp_valid));
      check_eq({tag, ".os"},    64'(out_os),    64'(exp_os));
      check_eq({tag, ".sync"},  64'(sync),      64'(m_sync));
      check_eq({tag, ".err"},   64'(err),       64'(exp_err));
      check_eq({tag, ".inv"},   64'(invalid_count), STATS ? 64'(m_inv) : 64'd0);
      check_eq({tag, ".los"},   64'(los_count),     STATS ? 64'(m_los) : 64'd0);
   endtask

   task automatic drive(input string tag, input logic [35:0] w, input logic v);
      rx_data  = w;
      rx_valid = v;
      model_step(w, v);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   // ---------------- stimulus words ----------------
   function automatic logic [35:0] idle_w();
      return mk_word(4'b0001, 32'hB5B595BC);
   endfunction
   function automatic logic [35:0] data_w();
      return mk_word(4'b0000, $urandom);
   endfunction
   function automatic logic [35:0] bad_w();
      return mk_word(4'b0101, 32'hB5B595BC);   // extra K on byte 2
   endfunction

   task automatic rand_word(output logic [35:0] w, output logic v);
      int r;
      logic [31:0] b;
      r = $urandom_range(0, 9);
      b = $urandom;
      v = 1'b1;
      if (r <= 3)      w = mk_word(4'b0001, {b[31:8], 8'hBC});
      else if (r <= 6) w = mk_word(4'b0000, b);
      else if (r == 7) begin w = mk_word(4'($urandom), b); v = 1'b0; end
      else if (r == 8) w = mk_word(4'b0001 | (4'b0001 << $urandom_range(1, 3)), {b[31:8], 8'hBC});
      else             w = mk_word(4'b0001, {b[31:8], (b[7:0] == 8'hBC) ? 8'h1C : b[7:0]});
   endtask

   task automatic acquire(input string tag);
      for (int i = 0; i < int'(ACQ_N); i++) drive(tag, idle_w(), 1'b1);
   endtask

   initial begin
      logic [35:0] w;
      logic        v;

      reset_n  = 1'b0;
      rx_data  = '0;
      rx_valid = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // Acquisition on three IDLEs: first two not forwarded, third is.
      drive("idle1", idle_w(), 1'b1);
      check_eq("idle1_valid", 64'(out_valid), 64'd0);
      drive("idle2", idle_w(), 1'b1);
      check_eq("idle2_sync", 64'(sync), 64'd0);
      drive("idle3", idle_w(), 1'b1);
      check_eq("idle3_sync", 64'(sync), 64'd1);
      check_eq("idle3_os", 64'({out_valid, out_os}), 64'd3);

      // Four back-to-back invalid words lose sync.
      for (int i = 0; i < 4; i++) drive("loss", bad_w(), 1'b1);
      check_eq("loss_sync", 64'(sync), 64'd0);
      check_eq("loss_los", 64'(los_count), STATS ? 64'd1 : 64'd0);
      check_eq("loss_inv", 64'(invalid_count), STATS ? 64'd4 : 64'd0);

      // Error credit cancelled by pairs of valid words.
      acquire("reacq");
      for (int i = 0; i < 10; i++) begin
         drive("osc_bad", bad_w(), 1'b1);
         drive("osc_ok1", data_w(), 1'b1);
         drive("osc_ok2", idle_w(), 1'b1);
      end
      check_eq("osc_sync", 64'(sync), 64'd1);
      for (int i = 0; i < 3; i++) begin
         drive("alt_bad", bad_w(), 1'b1);
         drive("alt_ok", data_w(), 1'b1);
      end
      check_eq("alt_hold", 64'(sync), 64'd1);
      drive("alt_bad4", bad_w(), 1'b1);
      check_eq("alt_drop", 64'(sync), 64'd0);

      // Data word in ACQ does not disturb the OS count.
      drive("acq_os1", idle_w(), 1'b1);
      drive("acq_os2", idle_w(), 1'b1);
      drive("acq_data", data_w(), 1'b1);
      check_eq("acq_data_sync", 64'(sync), 64'd0);
      drive("acq_os3", idle_w(), 1'b1);
      check_eq("acq_data_ok", 64'(sync), 64'd1);

      // rx_valid low in ACQ restarts acquisition.
      for (int i = 0; i < 4; i++) drive("drop", bad_w(), 1'b1);
      drive("rst_os1", idle_w(), 1'b1);
      drive("rst_os2", idle_w(), 1'b1);
      drive("rst_nv", idle_w(), 1'b0);
      drive("rst_os3", idle_w(), 1'b1);
      drive("rst_os4", idle_w(), 1'b1);
      check_eq("restart_sync", 64'(sync), 64'd0);
      drive("rst_os5", idle_w(), 1'b1);
      check_eq("restart_acq", 64'(sync), 64'd1);

      // Asynchronous reset while synced.
      drive("pre_async", data_w(), 1'b1);
      check_eq("pre_async_valid", 64'(out_valid), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("async_sync", 64'(sync), 64'd0);
      check_eq("async_valid", 64'(out_valid), 64'd0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      check_eq("async_inv", 64'(invalid_count), 64'd0);
      check_eq("async_los", 64'(los_count), 64'd0);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         rand_word(w, v);
         drive("rand", w, v);
      end

      // Counter saturation.
      for (int i = 0; i < int'(CNT_MAX) + 20; i++) drive("satr", bad_w(), 1'b1);
      check_eq("sat_inv", 64'(invalid_count), STATS ? 64'(CNT_MAX) : 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
